// File: rtl/weapon_anchor_if.sv
// Signal bundle between character/mouse control (master) and weapon_anchor_ctrl (slave).
// Widths follow the controller's POS_W, N_WPN and ATTACK_TICKS.
interface weapon_anchor_if #(
  parameter int POS_W        = 12,
  parameter int N_WPN        = 3,
  parameter int ATTACK_TICKS = 16
);
  localparam int SEL_W = (N_WPN > 1) ? $clog2(N_WPN) : 1;
  localparam int FRM_W = (ATTACK_TICKS > 1) ? $clog2(ATTACK_TICKS) : 1;

  logic                   frame_tick;
  logic                   mouse_clicked;
  logic [SEL_W-1:0]       weapon_sel;
  logic [POS_W-1:0]       pos_x;
  logic [POS_W-1:0]       pos_y;
  logic [POS_W-1:0]       mouse_x;
  logic                   draw_weapon;
  logic                   flip_hor;
  logic [SEL_W-1:0]       active_sel;
  logic [FRM_W-1:0]       attack_frame;
  logic                   fire_pulse;
  logic [N_WPN*POS_W-1:0] anchor_x;
  logic [N_WPN*POS_W-1:0] anchor_y;

  modport master (
    output frame_tick, mouse_clicked, weapon_sel, pos_x, pos_y, mouse_x,
    input  draw_weapon, flip_hor, active_sel, attack_frame, fire_pulse, anchor_x, anchor_y
  );

  modport slave (
    input  frame_tick, mouse_clicked, weapon_sel, pos_x, pos_y, mouse_x,
    output draw_weapon, flip_hor, active_sel, attack_frame, fire_pulse, anchor_x, anchor_y
  );
endinterface

// File: rtl/weapon_anchor_ctrl.sv
// Weapon anchor / attack controller: input regs -> attack FSM -> anchor and output regs.
// Define WEAPON_ANCHOR_CLAMP_EN to saturate anchors to [0, X_MAX] / [0, Y_MAX] instead of wrapping.
module weapon_anchor_ctrl #(
  parameter int                     POS_W          = 12,
  parameter int                     N_WPN          = 3,
  parameter int                     OFF_W          = 8,
  parameter logic [N_WPN*OFF_W-1:0] WPN_X_OFF      = {8'd30, 8'd10, 8'd40},
  parameter logic [N_WPN*OFF_W-1:0] WPN_Y_OFF      = {8'hFC, 8'd12, 8'd15},
  parameter logic [N_WPN-1:0]       RANGED_MASK    = 3'b010,
  parameter int                     ATTACK_TICKS   = 16,
  parameter int                     COOLDOWN_TICKS = 8,
  parameter int                     X_MAX          = 1023,
  parameter int                     Y_MAX          = 767
) (
  input  logic           clk,
  input  logic           rst,
  weapon_anchor_if.slave bus
);
  localparam int SEL_W   = (N_WPN > 1) ? $clog2(N_WPN) : 1;
  localparam int FRM_W   = (ATTACK_TICKS > 1) ? $clog2(ATTACK_TICKS) : 1;
  localparam int CNT_MAX = (ATTACK_TICKS > COOLDOWN_TICKS) ? ATTACK_TICKS : COOLDOWN_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ATK_LAST = CNT_W'(ATTACK_TICKS - 1);
  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_TICKS - 1);

  if (N_WPN < 32'sd1 || ATTACK_TICKS < 32'sd1 || COOLDOWN_TICKS < 32'sd0 || OFF_W >= POS_W ||
      X_MAX < 32'sd0 || Y_MAX < 32'sd0 ||
      X_MAX >= (32'sd1 <<< POS_W) || Y_MAX >= (32'sd1 <<< POS_W)) begin : g_bad_params
    $error("weapon_anchor_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ATTACK   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  function automatic logic [POS_W-1:0] x_off(input int k);
    x_off = {{(POS_W-OFF_W){1'b0}}, WPN_X_OFF[k*OFF_W +: OFF_W]};
  endfunction

  function automatic logic [POS_W-1:0] y_off(input int k);
    logic [OFF_W-1:0] f;
    f     = WPN_Y_OFF[k*OFF_W +: OFF_W];
    y_off = {{(POS_W-OFF_W){f[OFF_W-1]}}, f};
  endfunction

  logic             tick_r, click_r;
  logic [SEL_W-1:0] sel_in_r;
  logic [POS_W-1:0] pos_x_r, pos_y_r, mouse_x_r;
  logic             sel_ok_s;

  assign sel_ok_s = (int'(bus.weapon_sel) < N_WPN);

  // Stage 1: input capture; out-of-range selections fold to channel 0 here
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r    <= 1'b0;
      click_r   <= 1'b0;
      sel_in_r  <= {SEL_W{1'b0}};
      pos_x_r   <= {POS_W{1'b0}};
      pos_y_r   <= {POS_W{1'b0}};
      mouse_x_r <= {POS_W{1'b0}};
    end else begin
      tick_r    <= bus.frame_tick;
      click_r   <= bus.mouse_clicked;
      sel_in_r  <= sel_ok_s ? bus.weapon_sel : {SEL_W{1'b0}};
      pos_x_r   <= bus.pos_x;
      pos_y_r   <= bus.pos_y;
      mouse_x_r <= bus.mouse_x;
    end
  end

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             facing_r, facing_s;
  logic [SEL_W-1:0] sel_r, sel_s;
  logic             entry_r, entry_s;
  logic [POS_W-1:0] pos_x_2r, pos_y_2r;

  // Stage 2 next-state: a tick seen on the entry cycle is not counted (state is still IDLE)
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    facing_s = facing_r;
    sel_s    = sel_r;
    entry_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (click_r) begin
          state_s  = ST_ATTACK;
          cnt_s    = {CNT_W{1'b0}};
          facing_s = (mouse_x_r <= pos_x_r);
          sel_s    = sel_in_r;
          entry_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ATTACK: begin
        if (tick_r && (cnt_r == ATK_LAST)) begin
          cnt_s = {CNT_W{1'b0}};
          if (COOLDOWN_TICKS == 0) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_COOLDOWN;
          end
        end else if (tick_r) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_COOLDOWN: begin
        if (tick_r && (cnt_r == CD_LAST)) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_IDLE;
        end else if (tick_r) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Stage 2 registers: FSM, latched facing/selection, delayed position
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      facing_r <= 1'b0;
      sel_r    <= {SEL_W{1'b0}};
      entry_r  <= 1'b0;
      pos_x_2r <= {POS_W{1'b0}};
      pos_y_2r <= {POS_W{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      facing_r <= facing_s;
      sel_r    <= sel_s;
      entry_r  <= entry_s;
      pos_x_2r <= pos_x_r;
      pos_y_2r <= pos_y_r;
    end
  end

  logic [N_WPN*POS_W-1:0] anchor_x_s, anchor_y_s;

`ifdef WEAPON_ANCHOR_CLAMP_EN
  localparam int EXT_W = POS_W + 2;

  function automatic logic [POS_W-1:0] sat(input logic signed [EXT_W-1:0] v, input int lim);
    if (v[EXT_W-1]) begin
      sat = {POS_W{1'b0}};
    end else if (v > $signed(EXT_W'(lim))) begin
      sat = POS_W'(lim);
    end else begin
      sat = v[POS_W-1:0];
    end
  endfunction

  logic signed [EXT_W-1:0] xe_s, ye_s;

  // Stage 3 anchors, widened so under/overflow can be saturated
  always_comb begin
    anchor_x_s = {(N_WPN*POS_W){1'b0}};
    anchor_y_s = {(N_WPN*POS_W){1'b0}};
    xe_s       = {EXT_W{1'b0}};
    ye_s       = {EXT_W{1'b0}};
    for (int k = 0; k < N_WPN; k++) begin
      if (facing_r) begin
        xe_s = $signed({2'b00, pos_x_2r}) - $signed({2'b00, x_off(k)});
      end else begin
        xe_s = $signed({2'b00, pos_x_2r}) + $signed({2'b00, x_off(k)});
      end
      ye_s = $signed({2'b00, pos_y_2r}) + $signed({{2{y_off(k)[POS_W-1]}}, y_off(k)});
      anchor_x_s[k*POS_W +: POS_W] = sat(xe_s, X_MAX);
      anchor_y_s[k*POS_W +: POS_W] = sat(ye_s, Y_MAX);
    end
  end
`else
  // Stage 3 anchors, modulo 2^POS_W
  always_comb begin
    anchor_x_s = {(N_WPN*POS_W){1'b0}};
    anchor_y_s = {(N_WPN*POS_W){1'b0}};
    for (int k = 0; k < N_WPN; k++) begin
      if (facing_r) begin
        anchor_x_s[k*POS_W +: POS_W] = pos_x_2r - x_off(k);
      end else begin
        anchor_x_s[k*POS_W +: POS_W] = pos_x_2r + x_off(k);
      end
      anchor_y_s[k*POS_W +: POS_W] = pos_y_2r + y_off(k);
    end
  end
`endif

  logic                   draw_r, flip_r, fire_r;
  logic [SEL_W-1:0]       active_sel_r;
  logic [FRM_W-1:0]       frame_r;
  logic [N_WPN*POS_W-1:0] anchor_x_r, anchor_y_r;

  // Stage 3 output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      draw_r       <= 1'b0;
      flip_r       <= 1'b0;
      fire_r       <= 1'b0;
      active_sel_r <= {SEL_W{1'b0}};
      frame_r      <= {FRM_W{1'b0}};
      anchor_x_r   <= {(N_WPN*POS_W){1'b0}};
      anchor_y_r   <= {(N_WPN*POS_W){1'b0}};
    end else begin
      draw_r       <= (state_r == ST_ATTACK);
      flip_r       <= facing_r;
      fire_r       <= entry_r & RANGED_MASK[sel_r];
      active_sel_r <= sel_r;
      frame_r      <= (state_r == ST_ATTACK) ? cnt_r[FRM_W-1:0] : {FRM_W{1'b0}};
      anchor_x_r   <= anchor_x_s;
      anchor_y_r   <= anchor_y_s;
    end
  end

  assign bus.draw_weapon  = draw_r;
  assign bus.flip_hor     = flip_r;
  assign bus.fire_pulse   = fire_r;
  assign bus.active_sel   = active_sel_r;
  assign bus.attack_frame = frame_r;
  assign bus.anchor_x     = anchor_x_r;
  assign bus.anchor_y     = anchor_y_r;
endmodule

// File: tb/tb_weapon_anchor_ctrl.sv
// Directed bench for weapon_anchor_ctrl: vector table plus hand-written attack/cooldown/reset sequences.
// Expectations follow WEAPON_ANCHOR_CLAMP_EN when it is defined.
module tb_weapon_anchor_ctrl;
  localparam int POS_W = 12;
  localparam int N_WPN = 3;
  localparam int ATK   = 4;
  localparam int CD    = 2;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  weapon_anchor_if #(.POS_W(POS_W), .N_WPN(N_WPN), .ATTACK_TICKS(ATK)) bus ();

  weapon_anchor_ctrl #(
    .POS_W(POS_W), .N_WPN(N_WPN), .ATTACK_TICKS(ATK), .COOLDOWN_TICKS(CD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0]      px;
    logic [11:0]      py;
    logic [11:0]      mx;
    logic [1:0]       sel;
    logic             flip;
    logic [1:0]       asel;
    logic             fire;
    logic [2:0][11:0] ax;
    logic [2:0][11:0] ay;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One frame tick followed by 9 quiet cycles; draw/fire recorded after each edge
  task automatic do_tick(output logic [9:0] dv, output logic [9:0] fv);
    bus.frame_tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.frame_tick = 1'b0;
      dv[i] = bus.draw_weapon;
      fv[i] = bus.fire_pulse;
    end
  endtask

  logic [9:0] dv, fv;
  logic       seen;

  initial begin
    vecs[0] = '{12'd100, 12'd200, 12'd300, 2'd0, 1'b0, 2'd0, 1'b0,
                {12'd130, 12'd110, 12'd140}, {12'd196, 12'd212, 12'd215}};
    vecs[1] = '{12'd100, 12'd200, 12'd100, 2'd1, 1'b1, 2'd1, 1'b1,
                {12'd70, 12'd90, 12'd60}, {12'd196, 12'd212, 12'd215}};
`ifdef WEAPON_ANCHOR_CLAMP_EN
    vecs[2] = '{12'd5, 12'd4090, 12'd0, 2'd2, 1'b1, 2'd2, 1'b0,
                {12'd0, 12'd0, 12'd0}, {12'd767, 12'd767, 12'd767}};
    vecs[3] = '{12'd4080, 12'd10, 12'd4095, 2'd3, 1'b0, 2'd0, 1'b0,
                {12'd1023, 12'd1023, 12'd1023}, {12'd6, 12'd22, 12'd25}};
`else
    vecs[2] = '{12'd5, 12'd4090, 12'd0, 2'd2, 1'b1, 2'd2, 1'b0,
                {12'd4071, 12'd4091, 12'd4061}, {12'd4086, 12'd6, 12'd9}};
    vecs[3] = '{12'd4080, 12'd10, 12'd4095, 2'd3, 1'b0, 2'd0, 1'b0,
                {12'd14, 12'd4090, 12'd24}, {12'd6, 12'd22, 12'd25}};
`endif
    vecs[4] = '{12'd50, 12'd60, 12'd49, 2'd1, 1'b1, 2'd1, 1'b1,
                {12'd20, 12'd40, 12'd10}, {12'd56, 12'd72, 12'd75}};

    // Reset with busy inputs: every output must read 0
    rst = 1'b1;
    bus.frame_tick = 1'b1; bus.mouse_clicked = 1'b1; bus.weapon_sel = 2'd1;
    bus.pos_x = 12'd100; bus.pos_y = 12'd200; bus.mouse_x = 12'd50;
    repeat (4) step();
    chk("rst_draw", bus.draw_weapon, 1'b0);
    chk("rst_flip", bus.flip_hor, 1'b0);
    chk("rst_asel", bus.active_sel, 2'd0);
    chk("rst_frame", bus.attack_frame, 2'd0);
    chk("rst_fire", bus.fire_pulse, 1'b0);
    chk("rst_ax_any", |bus.anchor_x, 1'b0);
    chk("rst_ay_any", |bus.anchor_y, 1'b0);

    bus.frame_tick = 1'b0; bus.mouse_clicked = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.draw_weapon || bus.fire_pulse) seen = 1'b1;
    end
    chk("idle_no_attack", seen, 1'b0);

    for (int i = 0; i < 5; i++) begin
      bus.pos_x = vecs[i].px; bus.pos_y = vecs[i].py; bus.mouse_x = vecs[i].mx;
      bus.weapon_sel = vecs[i].sel;
      bus.mouse_clicked = 1'b1;
      step();
      bus.mouse_clicked = 1'b0;
      step();
      chk($sformatf("v%0d_draw_early", i), bus.draw_weapon, 1'b0);
      step();
      chk($sformatf("v%0d_draw", i), bus.draw_weapon, 1'b1);
      chk($sformatf("v%0d_flip", i), bus.flip_hor, vecs[i].flip);
      chk($sformatf("v%0d_asel", i), bus.active_sel, vecs[i].asel);
      chk($sformatf("v%0d_fire", i), bus.fire_pulse, vecs[i].fire);
      chk($sformatf("v%0d_frame", i), bus.attack_frame, 2'd0);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("v%0d_ax%0d", i, k), bus.anchor_x[k*POS_W +: POS_W], vecs[i].ax[k]);
        chk($sformatf("v%0d_ay%0d", i, k), bus.anchor_y[k*POS_W +: POS_W], vecs[i].ay[k]);
      end
      step();
      chk($sformatf("v%0d_fire_once", i), bus.fire_pulse, 1'b0);
      chk($sformatf("v%0d_draw_hold", i), bus.draw_weapon, 1'b1);
      for (int t = 0; t < ATK + CD; t++) do_tick(dv, fv);
      chk($sformatf("v%0d_back_idle", i), bus.draw_weapon, 1'b0);
    end

    // Held click: 4 ticks of ATTACK, 2 of COOLDOWN, then auto-repeat with the new selection
    bus.pos_x = 12'd100; bus.pos_y = 12'd200; bus.mouse_x = 12'd300;
    bus.weapon_sel = 2'd0;
    bus.mouse_clicked = 1'b1;
    repeat (3) step();
    chk("rep_draw", bus.draw_weapon, 1'b1);
    chk("rep_frame0", bus.attack_frame, 2'd0);
    bus.weapon_sel = 2'd1;
    for (int t = 1; t <= 3; t++) begin
      do_tick(dv, fv);
      chk($sformatf("rep_draw_t%0d", t), dv, 10'h3FF);
      chk($sformatf("rep_frame_t%0d", t), bus.attack_frame, t);
      chk($sformatf("rep_asel_t%0d", t), bus.active_sel, 2'd0);
    end
    do_tick(dv, fv);
    chk("rep_draw_end", dv, 10'h003);
    chk("rep_frame_cd", bus.attack_frame, 2'd0);
    chk("rep_asel_cd", bus.active_sel, 2'd0);
    do_tick(dv, fv);
    chk("rep_draw_cd2", dv, 10'h000);
    do_tick(dv, fv);
    chk("rep_draw_restart", dv, 10'h3F8);
    chk("rep_fire_restart", fv, 10'h008);
    chk("rep_asel_new", bus.active_sel, 2'd1);
    chk("rep_flip", bus.flip_hor, 1'b0);
    bus.mouse_clicked = 1'b0;
    for (int t = 0; t < ATK + CD; t++) do_tick(dv, fv);
    chk("rep_idle", bus.draw_weapon, 1'b0);

    // Entry tick ignored, then reset aborts an attack at frame 2
    bus.mouse_x = 12'd50; bus.weapon_sel = 2'd1;
    bus.mouse_clicked = 1'b1; bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step(); step();
    chk("ab_draw", bus.draw_weapon, 1'b1);
    chk("ab_fire", bus.fire_pulse, 1'b1);
    chk("ab_flip", bus.flip_hor, 1'b1);
    step();
    chk("ab_entry_tick", bus.attack_frame, 2'd0);
    do_tick(dv, fv);
    do_tick(dv, fv);
    chk("ab_frame2", bus.attack_frame, 2'd2);
    rst = 1'b1;
    step();
    chk("ab_rst_draw", bus.draw_weapon, 1'b0);
    chk("ab_rst_flip", bus.flip_hor, 1'b0);
    chk("ab_rst_asel", bus.active_sel, 2'd0);
    chk("ab_rst_frame", bus.attack_frame, 2'd0);
    chk("ab_rst_fire", bus.fire_pulse, 1'b0);
    chk("ab_rst_ax_any", |bus.anchor_x, 1'b0);
    chk("ab_rst_ay_any", |bus.anchor_y, 1'b0);
    rst = 1'b0;
    step();
    step();
    chk("ab_restart_early", bus.draw_weapon, 1'b0);
    step();
    chk("ab_restart_draw", bus.draw_weapon, 1'b1);
    chk("ab_restart_frame", bus.attack_frame, 2'd0);
    chk("ab_restart_fire", bus.fire_pulse, 1'b1);
    chk("ab_restart_asel", bus.active_sel, 2'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
